// File: rtl/music_sequencer_if.sv
// Control, ROM and audio-datapath signals of the background-music sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface music_sequencer_if;
    logic        play_en;
    logic        restart;
    logic        vol_up;
    logic        vol_down;
    logic        mute;
    logic [5:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] note_freq;
    logic [15:0] amp_hi;
    logic [15:0] amp_lo;
    logic [2:0]  volume;
    logic [5:0]  beat_idx;
    logic        beat_tick;

    modport slave (
        input  play_en, restart, vol_up, vol_down, mute, rom_data,
        output rom_addr, note_freq, amp_hi, amp_lo, volume, beat_idx, beat_tick
    );

    modport master (
        output play_en, restart, vol_up, vol_down, mute, rom_data,
        input  rom_addr, note_freq, amp_hi, amp_lo, volume, beat_idx, beat_tick
    );
endinterface

// File: rtl/music_sequencer.sv
// Walks a note ROM at a fixed tempo and drives note frequency plus a volume-scaled
// amplitude pair to the note generator; owns the volume level and mute.
module music_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000,
    parameter int unsigned SONG_LEN    = 64,
    parameter int unsigned VOL_RESET   = 3
) (
    input  logic             clk,
    input  logic             rst,
    music_sequencer_if.slave bus
);
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned FREQ_W      = 16;
    localparam int unsigned VOL_W       = 3;
    localparam int unsigned PLAY_CYCLES = BEAT_CYCLES - GAP_CYCLES - 2;
    localparam int unsigned CNT_W       = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [FREQ_W-1:0]   r_note, w_note_nxt;
    logic                r_tick, w_tick_nxt;
    logic [VOL_W-1:0]    r_vol, w_vol_nxt;
    logic [FREQ_W-1:0]   w_amp_mag;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_note  <= '0;
            r_tick  <= 1'b0;
            r_vol   <= VOL_W'(VOL_RESET);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_note  <= w_note_nxt;
            r_tick  <= w_tick_nxt;
            r_vol   <= w_vol_nxt;
        end
    end

    // Beat sequencing; pause and restart override the normal walk, restart last
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_note_nxt  = r_note;

        unique case (r_state)
            S_IDLE: begin
                w_note_nxt = '0;
                w_cnt_nxt  = '0;
                if (bus.play_en) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_note_nxt  = bus.rom_data;
                w_cnt_nxt   = '0;
                w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (r_cnt == CNT_W'(PLAY_CYCLES - 1)) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                    w_note_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = S_FETCH;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == IDX_W'(SONG_LEN - 1)) ? '0 : r_idx + IDX_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_note_nxt  = '0;
            end
        endcase

        if (!bus.play_en && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_note_nxt  = '0;
            w_idx_nxt   = r_idx;
        end

        if (bus.restart) begin
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_note_nxt  = '0;
            w_state_nxt = bus.play_en ? S_FETCH : S_IDLE;
        end
    end

    // Tick is registered, so it is raised on entry to the last GAP cycle
    always_comb begin
        w_tick_nxt = (w_state_nxt == S_GAP) && (w_cnt_nxt == CNT_W'(GAP_CYCLES - 1));
    end

    // Saturating volume; simultaneous up and down cancel
    always_comb begin
        w_vol_nxt = r_vol;
        if (bus.vol_up && !bus.vol_down && r_vol != '1) begin
            w_vol_nxt = r_vol + VOL_W'(1);
        end else if (bus.vol_down && !bus.vol_up && r_vol != '0) begin
            w_vol_nxt = r_vol - VOL_W'(1);
        end
    end

    always_comb begin
        w_amp_mag = {1'b0, r_vol, 12'd0};
    end

    assign bus.rom_addr  = r_idx;
    assign bus.note_freq = r_note;
    assign bus.amp_hi    = bus.mute ? '0 : w_amp_mag;
    assign bus.amp_lo    = bus.mute ? '0 : (~w_amp_mag + 16'd1);
    assign bus.volume    = r_vol;
    assign bus.beat_idx  = r_idx;
    assign bus.beat_tick = r_tick;

endmodule
